// File: rtl/psk_pkg.sv
// psk_pkg: FSM encodings and parameter defaults shared by the PSK
// transmitter and demodulator, plus a counter-width helper.
package psk_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RUNNING = 1'b1;

  localparam int PSK_CLKS_PER_BIT_DEF    = 4;
  localparam int PSK_BITS_PER_SYMBOL_DEF = 4;
  localparam int PSK_REPEATED_SAMPLE_DEF = 30;

  // $clog2 with a 1-bit floor so single-value counters stay legal
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/psk_bit_sampler.sv
// psk_bit_sampler: picks the bit value out of one bit period.
// Ports: din, counter_clks in; bit_o, strobe_o out.
// PSK_DEMOD_MAJORITY_EN: adds clk/rst/en and votes 2-of-3 over
// samples at C/4, C/2 and 3C/4; otherwise one mid-bit sample.
module psk_bit_sampler #(
  parameter int CLKS = 4,
  parameter int CW   = 2
) (
`ifdef PSK_DEMOD_MAJORITY_EN
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`endif
  input  logic          din,
  input  logic [CW-1:0] counter_clks,
  output logic          bit_o,
  output logic          strobe_o
);

`ifdef PSK_DEMOD_MAJORITY_EN
  localparam logic [CW-1:0] Q1 = CW'(CLKS / 4);
  localparam logic [CW-1:0] Q2 = CW'(CLKS / 2);
  localparam logic [CW-1:0] Q3 = CW'((3 * CLKS) / 4);

  if (CLKS < 4) begin : g_bad_clks
    $error("psk_bit_sampler: majority needs CLKS >= 4");
  end

  logic v0_q, v0_d;
  logic v1_q, v1_d;

  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    if (en && counter_clks == Q1) v0_d = din;
    if (en && counter_clks == Q2) v1_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end

  // third vote is the live line value
  assign strobe_o = (counter_clks == Q3);
  assign bit_o    = (v0_q & v1_q) | (v0_q & din) | (v1_q & din);
`else
  localparam logic [CW-1:0] MID = CW'(CLKS / 2);

  assign strobe_o = (counter_clks == MID);
  assign bit_o    = din;
`endif

endmodule

// File: rtl/psk_demodulator.sv
// psk_demodulator: recovers repeated PSK symbols into 8-bit FIFO words.
// Ports: clk, rst (sync, high), enable, din, sof, full in;
// write, data[7:0], mismatch, overflow out.
// PSK_DEMOD_MAJORITY_EN selects 2-of-3 bit voting in psk_bit_sampler.
module psk_demodulator
  import psk_pkg::*;
#(
  parameter int PSK_CLKS_PER_BIT    = PSK_CLKS_PER_BIT_DEF,
  parameter int PSK_BITS_PER_SYMBOL = PSK_BITS_PER_SYMBOL_DEF,
  parameter int PSK_REPEATED_SAMPLE = PSK_REPEATED_SAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       din,
  input  logic       sof,
  input  logic       full,
  output logic       write,
  output logic [7:0] data,
  output logic       mismatch,
  output logic       overflow
);

  localparam int CW = cnt_w(PSK_CLKS_PER_BIT);
  localparam int BW = cnt_w(PSK_BITS_PER_SYMBOL);
  localparam int RW = cnt_w(PSK_REPEATED_SAMPLE);

  localparam logic [CW-1:0] CLK_LAST = CW'(PSK_CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PSK_BITS_PER_SYMBOL - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(PSK_REPEATED_SAMPLE - 1);

  logic [0:0]    st_q, st_d;
  logic [CW-1:0] cnt_clks_q, cnt_clks_d;
  logic [BW-1:0] cnt_bits_q, cnt_bits_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [7:0]    cur_word_q, cur_word_d;
  logic [7:0]    ref_word_q, ref_word_d;
  logic          acc_q, acc_d;
  logic          write_q, write_d;
  logic [7:0]    data_q, data_d;
  logic          mismatch_q, mismatch_d;
  logic          overflow_q, overflow_d;

  logic       running;
  logic       smp_gate;
  logic       raw_bit;
  logic       raw_stb;
  logic       smp_stb;
  logic [7:0] word_now;
  logic [7:0] ref_now;
  logic       acc_now;

  assign running  = (st_q == ST_RUNNING);
  // sof cycles are clk 0 of a fresh sample, never a sample point
  assign smp_gate = enable & running & ~sof;
  assign smp_stb  = raw_stb & smp_gate;

  psk_bit_sampler #(
    .CLKS (PSK_CLKS_PER_BIT),
    .CW   (CW)
  ) u_sampler (
`ifdef PSK_DEMOD_MAJORITY_EN
    .clk          (clk),
    .rst          (rst),
    .en           (smp_gate),
`endif
    .din          (din),
    .counter_clks (cnt_clks_q),
    .bit_o        (raw_bit),
    .strobe_o     (raw_stb)
  );

  always_comb begin
    st_d       = st_q;
    cnt_clks_d = cnt_clks_q;
    cnt_bits_d = cnt_bits_q;
    rep_d      = rep_q;
    cur_word_d = cur_word_q;
    ref_word_d = ref_word_q;
    acc_d      = acc_q;
    data_d     = data_q;
    // status outputs are strict one-cycle pulses, even across enable=0
    write_d    = 1'b0;
    mismatch_d = 1'b0;
    overflow_d = 1'b0;

    // the last bit can land on the symbol-end cycle, so fold it in now
    word_now = cur_word_q;
    if (smp_stb) word_now[cnt_bits_q] = raw_bit;

    ref_now = (rep_q == '0) ? word_now : ref_word_q;
    acc_now = (rep_q == '0) ? 1'b0
            : (acc_q | (word_now != ref_word_q));

    if (enable) begin
      if (sof) begin
        st_d       = ST_RUNNING;
        cnt_clks_d = CW'(1);
        cnt_bits_d = '0;
        rep_d      = '0;
        cur_word_d = '0;
        acc_d      = 1'b0;
      end else if (running) begin
        cur_word_d = word_now;
        if (cnt_clks_q == CLK_LAST) begin
          cnt_clks_d = '0;
          if (cnt_bits_q == BIT_LAST) begin
            cnt_bits_d = '0;
            cur_word_d = '0;
            ref_word_d = ref_now;
            acc_d      = acc_now;
            if (rep_q == REP_LAST) begin
              rep_d = '0;
              if (full) begin
                overflow_d = 1'b1;
              end else begin
                write_d    = 1'b1;
                data_d     = ref_now;
                mismatch_d = acc_now;
              end
            end else begin
              rep_d = rep_q + 1'b1;
            end
          end else begin
            cnt_bits_d = cnt_bits_q + 1'b1;
          end
        end else begin
          cnt_clks_d = cnt_clks_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      cnt_clks_q <= '0;
      cnt_bits_q <= '0;
      rep_q      <= '0;
      cur_word_q <= '0;
      ref_word_q <= '0;
      acc_q      <= 1'b0;
      write_q    <= 1'b0;
      data_q     <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_clks_q <= cnt_clks_d;
      cnt_bits_q <= cnt_bits_d;
      rep_q      <= rep_d;
      cur_word_q <= cur_word_d;
      ref_word_q <= ref_word_d;
      acc_q      <= acc_d;
      write_q    <= write_d;
      data_q     <= data_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
    end
  end

  assign write    = write_q;
  assign data     = data_q;
  assign mismatch = mismatch_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_psk_demodulator.sv
// tb_psk_demodulator: directed + randomized line streams against a
// sample-position reference model of the demodulator.
module tb_psk_demodulator;

`ifdef PSK_DEMOD_MAJORITY_EN
  localparam int C = 8;
`else
  localparam int C = 4;
`endif
  localparam int B = 4;
  localparam int R = 2;
  localparam int N = C * B * R;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       din = 1'b0;
  logic       sof = 1'b0;
  logic       full = 1'b0;
  logic       write;
  logic [7:0] data;
  logic       mismatch;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int ov_cnt = 0;

  // model state: k = enabled-cycle index within the current sample
  int         k = -1;
  logic       line [0:1023];
  logic       ew = 1'b0;
  logic       eo = 1'b0;
  logic       em = 1'b0;
  logic [7:0] ed = 8'h00;

  psk_demodulator #(
    .PSK_CLKS_PER_BIT    (C),
    .PSK_BITS_PER_SYMBOL (B),
    .PSK_REPEATED_SAMPLE (R)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .din      (din),
    .sof      (sof),
    .full     (full),
    .write    (write),
    .data     (data),
    .mismatch (mismatch),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input int base);
    logic a, b2, c2;
`ifdef PSK_DEMOD_MAJORITY_EN
    a  = line[base + C / 4];
    b2 = line[base + C / 2];
    c2 = line[base + (3 * C) / 4];
    return (a & b2) | (a & c2) | (b2 & c2);
`else
    a  = line[base + C / 2];
    b2 = 1'b0;
    c2 = 1'b0;
    return a | (b2 & c2);
`endif
  endfunction

  // rebuild every repetition from recorded line values
  task automatic eval_sample(input logic f);
    logic [7:0] w;
    logic [7:0] rw;
    logic       mis;
    rw  = 8'h00;
    mis = 1'b0;
    for (int r = 0; r < R; r++) begin
      w = 8'h00;
      for (int b = 0; b < B; b++)
        w[b] = bit_at(r * C * B + b * C);
      if (r == 0) rw = w;
      else if (w != rw) mis = 1'b1;
    end
    if (f) begin
      eo = 1'b1;
    end else begin
      ew = 1'b1;
      ed = rw;
      em = mis;
    end
  endtask

  task automatic step(input logic s, input logic e,
                      input logic f, input logic d);
    sof = s;
    enable = e;
    full = f;
    din = d;
    @(posedge clk);
    ew = 1'b0;
    eo = 1'b0;
    em = 1'b0;
    if (rst) begin
      k  = -1;
      ed = 8'h00;
    end else if (e) begin
      if (s) begin
        k = 0;
        line[0] = d;
      end else if (k >= 0) begin
        k = (k + 1) % N;
        line[k] = d;
        if (k == N - 1) eval_sample(f);
      end
    end
    #1;
    chk("write", {7'd0, write}, {7'd0, ew});
    chk("overflow", {7'd0, overflow}, {7'd0, eo});
    chk("mismatch", {7'd0, mismatch}, {7'd0, em});
    chk("data", data, ed);
    if (write === 1'b1) wr_cnt++;
    if (overflow === 1'b1) ov_cnt++;
  endtask

  // transmitter: w0 on repetition 0, w1 on the rest, LSB first
  task automatic send(input logic [7:0] w0, input logic [7:0] w1,
                      input bit use_sof, input logic f,
                      input int ncyc, input int gap_at,
                      input int gap_len, input int glitch_at,
                      input bit rnd);
    int   r;
    int   b;
    logic bv;
    logic dv;
    logic [7:0] wv;
    for (int i = 0; i < ncyc; i++) begin
      r  = i / (C * B);
      b  = (i / C) % B;
      wv = (r == 0) ? w0 : w1;
      bv = wv[b];
      if (i == gap_at)
        repeat (gap_len) step(1'b0, 1'b0, f, bv);
      if (rnd && !(ew | eo) && $urandom_range(0, 7) == 0)
        step(1'($urandom_range(0, 1)), 1'b0, f, bv);
      dv = bv;
      if (i == glitch_at) dv = ~bv;
      if (rnd && $urandom_range(0, 23) == 0) dv = ~bv;
      step(use_sof && i == 0, 1'b1, f, dv);
    end
  endtask

  initial begin
    int w_exp;
    logic [7:0] a;
    logic [7:0] bw;
    rst = 1'b1;
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    repeat (6) step(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // loopback of 0xA5
    send(8'hA5, 8'hA5, 1, 0, N, -1, 0, -1, 0);
    chk("loop_data", data, 8'h05);
    chk("loop_wr", 8'(wr_cnt), 8'd1);
    // repetition error, back to back
    send(8'h05, 8'h06, 0, 0, N, -1, 0, -1, 0);
    chk("rep_err_wr", 8'(wr_cnt), 8'd2);
    // full across the sample end, then a normal sample
    send(8'h0C, 8'h0C, 1, 1, N, -1, 0, -1, 0);
    chk("ovf_cnt", 8'(ov_cnt), 8'd1);
    send(8'h03, 8'h03, 0, 0, N, -1, 0, -1, 0);
    chk("after_ovf", data, 8'h03);
    // resync at cycle 10
    send(8'h09, 8'h09, 1, 0, 10, -1, 0, -1, 0);
    send(8'h0A, 8'h0A, 1, 0, N, -1, 0, -1, 0);
    chk("resync_data", data, 8'h0A);
    chk("resync_wr", 8'(wr_cnt), 8'd4);
    // enable low for 5 cycles mid-stream
    send(8'h05, 8'h05, 1, 0, N, 8, 5, -1, 0);
    chk("gap_data", data, 8'h05);
    // single glitch at mid-bit of bit 2
    send(8'h05, 8'h05, 1, 0, N, -1, 0, 2 * C + C / 2, 0);
`ifdef PSK_DEMOD_MAJORITY_EN
    chk("maj_glitch", data, 8'h05);
`endif
    // reset mid-sample, then stream without sof stays idle
    send(8'h0F, 8'h0F, 1, 0, 20, -1, 0, -1, 0);
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    w_exp = wr_cnt;
    send(8'h0F, 8'h0F, 0, 0, N, -1, 0, -1, 0);
    chk("idle_no_wr", 8'(wr_cnt), 8'(w_exp));

    // randomized samples
    for (int n = 0; n < 40; n++) begin
      a  = 8'($urandom);
      bw = ($urandom_range(0, 2) == 0) ? 8'($urandom) : a;
      send(a, bw, ($urandom_range(0, 3) == 0) || n == 0,
           1'($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) == 0) ? $urandom_range(1, N - 1) : N,
           -1, 0, -1, 1);
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
